// File: rtl/mag_comp_arbiter.sv
// mag_comp_arbiter: round-robin shared unsigned magnitude comparator with registered eq/gr/lt and done pulse
module mag_comp_arbiter #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     a_in,
  input  logic [N_REQ*WIDTH-1:0]     b_in,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       done,
  output logic                       eq,
  output logic                       gr,
  output logic                       lt
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;
  state_t           r_state, w_next;
  logic [IW-1:0]    r_ptr, r_owner, w_win;
  logic [WIDTH-1:0] r_op_a, r_op_b;
  logic             r_eq, r_gr, r_lt;
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next state: a grant takes exactly three cycles, req only matters in IDLE
  always_comb begin
    w_next = (r_state == IDLE) ? (|req ? CMP : IDLE) : (r_state == CMP ? RESP : IDLE);
  end
  // winner is the first set request scanning upward from the pointer; the descending loop lets the nearest one win
  always_comb begin
    w_win = r_ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[r_ptr + IW'(k)]) w_win = r_ptr + IW'(k);
  end
  // datapath: latch operands at grant, compare once, rotate priority past the served owner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_eq    <= 1'b0;
      r_gr    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      if (r_state == IDLE && |req) begin
        r_owner <= w_win;
        r_op_a  <= a_in[w_win*WIDTH +: WIDTH];
        r_op_b  <= b_in[w_win*WIDTH +: WIDTH];
      end
      if (r_state == CMP) begin
        r_eq <= r_op_a == r_op_b;
        r_gr <= r_op_a > r_op_b;
        r_lt <= r_op_a < r_op_b;
      end
      if (r_state == RESP) r_ptr <= r_owner + 1'b1;
    end
  end
  // outputs decode from registered state only, so nothing flows straight from inputs
  always_comb begin
    gnt = '0;
    if (r_state != IDLE) gnt[r_owner] = 1'b1;
  end
  assign done  = r_state == RESP;
  assign owner = r_owner;
  assign eq    = r_eq;
  assign gr    = r_gr;
  assign lt    = r_lt;
endmodule

// File: tb/tb_mag_comp_arbiter.sv
// tb_mag_comp_arbiter: table vectors and hand sequences checked through an expected-result queue
module tb_mag_comp_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_in, b_in;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        done, eq, gr, lt;

  typedef struct {
    logic [1:0] owner;
    logic [2:0] flags;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  owner;
    logic [2:0]  flags;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mag_comp_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .owner(owner), .done(done), .eq(eq), .gr(gr), .lt(lt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(logic [1:0] o, logic [2:0] f);
    exp_t e;
    e.owner = o;
    e.flags = f;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    if (done) begin
      chk("done_with_gnt", 32'(gnt), 32'(1) << owner);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done for owner %0d, expected none", owner);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("owner", 32'(owner), 32'(e.owner));
        chk("flags_eq_gr_lt", 32'({eq, gr, lt}), 32'(e.flags));
      end
    end
  end

  task automatic await_done();
    int n = 0;
    while (!done && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(done), 1);
  endtask

  task automatic xact(vec_t v);
    req  = v.req;
    a_in = v.a;
    b_in = v.b;
    push(v.owner, v.flags);
    @(negedge clk);
    chk("grant", 32'(gnt), 32'(1) << v.owner);
    req  = 4'b0000;
    a_in = ~a_in;
    b_in = ~b_in;
    await_done();
    @(negedge clk);
    chk("done_fall", 32'(done), 0);
    chk("gnt_fall", 32'(gnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0010, 16'h0090, 16'h0010, 2'd1, 3'b010};
    tbl[1] = '{4'b1000, 16'h3000, 16'hE000, 2'd3, 3'b001};
    tbl[2] = '{4'b0100, 16'h0500, 16'h0500, 2'd2, 3'b100};
    tbl[3] = '{4'b0101, 16'h0C02, 16'h0407, 2'd0, 3'b001};
    tbl[4] = '{4'b0101, 16'h0C02, 16'h0407, 2'd2, 3'b010};
    tbl[5] = '{4'b0001, 16'h000F, 16'h0007, 2'd0, 3'b010};
    tbl[6] = '{4'b0010, 16'h0000, 16'h00F0, 2'd1, 3'b001};
    tbl[7] = '{4'b1010, 16'hF000, 16'hF000, 2'd3, 3'b100};
    tbl[8] = '{4'b1111, 16'h0000, 16'h0000, 2'd0, 3'b100};
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_flags", 32'({eq, gr, lt}), 0);

    req = 4'b0001; a_in = 16'h0008; b_in = 16'h0008;
    push(2'd0, 3'b100);
    @(negedge clk);
    chk("eq_gnt_k1", 32'(gnt), 32'h1);
    chk("eq_done_k1", 32'(done), 0);
    req = 4'b0000;
    @(negedge clk);
    chk("eq_done_k2", 32'(done), 1);
    chk("eq_flag_k2", 32'({eq, gr, lt}), 32'b100);
    @(negedge clk);
    chk("eq_done_k3", 32'(done), 0);
    chk("eq_gnt_k3", 32'(gnt), 0);
    chk("eq_hold_k3", 32'({eq, gr, lt}), 32'b100);

    for (int i = 0; i < 9; i++) xact(tbl[i]);

    rst = 1'b1; req = 4'b1111; a_in = 16'h5A3C; b_in = 16'h527C;
    @(negedge clk);
    rst = 1'b0;
    push(2'd0, 3'b100); push(2'd1, 3'b001); push(2'd2, 3'b010);
    push(2'd3, 3'b100); push(2'd0, 3'b100); push(2'd1, 3'b001);
    begin
      int last = 0;
      for (int j = 0; j < 6; j++) begin
        if (j > 0) @(negedge clk);
        await_done();
        if (j > 0) chk("rr_interval", 32'(cyc - last), 3);
        last = cyc;
      end
    end
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("rr_idle_gnt", 32'(gnt), 0);

    req = 4'b1000;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'h8);
    rst = 1'b1; req = 4'b1111;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_flags", 32'({eq, gr, lt}), 0);
    chk("mid_rst_owner", 32'(owner), 0);
    rst = 1'b0;
    push(2'd0, 3'b100);
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    await_done();
    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mag_comp_arbiter.md
# mag_comp_arbiter

Shares one 4-bit unsigned magnitude comparator between four requesters under round-robin arbitration. Each requester presents its own operand pair. The arbiter grants one requester, latches that requester's operands, runs a single comparison, and returns registered eq/gr/lt flags with a one-cycle done pulse. It sits in front of the dataflow comparator so that several lab datapaths can time-share one compare resource.

## Interface
- WIDTH, 4, operand width in bits; comparison is unsigned.
- N_REQ, 4, number of requesters; the index width is 2 bits.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request bits, one per requester; level-sensitive.
- a_in  input  16  packed operand A; requester i uses a_in[4i+3:4i].
- b_in  input  16  packed operand B; requester i uses b_in[4i+3:4i].
- gnt  output  4  one-hot grant; high from the grant edge until the request completes.
- owner  output  2  index of the current or most recent granted requester.
- done  output  1  one-cycle pulse; eq/gr/lt are valid for owner.
- eq  output  1  op_a == op_b.
- gr  output  1  op_a > op_b.
- lt  output  1  op_a < op_b.

## Operation
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Internal registers:
  - op_a, op_b: 4 bits each.
  - ptr: 2 bits, the highest-priority index.
  - state: 3 states, IDLE / CMP / RESP.
- IDLE:
  - If req is nonzero, the winner is the first set bit scanning ptr, ptr+1, … mod 4.
  - Latch op_a and op_b from the winner's slices.
  - Set gnt to one-hot(winner) and owner to winner, then go to CMP.
  - If req is 0, stay in IDLE with gnt=0.
- CMP:
  - Register eq/gr/lt from op_a and op_b. Exactly one of the three is set.
  - Set done to 1 and go to RESP.
- RESP:
  - done and gnt are high for this cycle.
  - At the edge, clear done and gnt, set ptr to owner+1 mod 4, and go to IDLE.
- Operands are sampled only at the IDLE grant edge. Changes to a_in/b_in after that edge have no effect on the current result.
- req is not re-sampled in CMP or RESP. Deasserting req mid-operation does not abort it.
- A requester that still holds req high after done is treated as a new request at lowest priority.
- eq/gr/lt and owner hold their values until the next CMP edge overwrites them. They stay valid after done falls.
- Reset values: state=IDLE, gnt=0000, owner=00, done=0, eq=gr=lt=0, ptr=00, op_a=op_b=0.
  - After reset, requester 0 has highest priority.
  - All-zero flags is legal only before the first compare.
- rst asserted in any state: everything returns to reset values at that edge.
  - An in-flight compare is discarded and no done is issued.
  - rst takes priority over every transition.

## Timing
- Request grant latency: req seen at edge k (state IDLE). gnt and owner change after edge k.
- Result latency:
  - eq/gr/lt/done are set after edge k+1.
  - done is high for exactly one cycle, between edges k+1 and k+2.
  - gnt falls after edge k+2.
- Throughput: one compare every 3 cycles. The next grant can occur at edge k+3.
- Under continuous contention, each active requester is served at least once every 12 cycles.
- gnt is at most one-hot at all times. done is never asserted while gnt=0000.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Basic equal:
  - Stimulus: after reset, req=0001, a0=1000, b0=1000 sampled at edge 1.
  - Required: gnt=0001 after edge 1; done=1, eq=1, gr=0, lt=0, owner=0 after edge 2; done=0, gnt=0000 after edge 3.
- Greater / less:
  - Stimulus: req=0010 with a1=1001, b1=0001.
  - Required: gr=1.
  - Stimulus: then req=1000 with a3=0011, b3=1110.
  - Required: lt=1, owner=3. In each case done pulses exactly once.
- Round-robin fairness:
  - Stimulus: req=1111 held constantly from reset.
  - Required: owner sequence 0,1,2,3,0,1; a new grant every 3 cycles; no done gaps beyond 2 idle cycles.
- Pointer skip:
  - Stimulus: after serving requester 2 (ptr=3), apply req=0101.
  - Required: the next grant goes to requester 0, then requester 2.
- Operand isolation:
  - Stimulus: grant requester 0 with a0=1111, b0=0111, then change a0 to 0000 the cycle after the grant.
  - Required: result gr=1.
- Reset mid-operation:
  - Stimulus: assert rst in the CMP cycle.
  - Required: after that edge, gnt=0000, done=0, eq=gr=lt=0, owner=0. No done appears. With req=1111 afterwards, requester 0 is granted first.
